hash_probe_sequencer: RTL and testbench

HASH_PROBE_SEQUENCER -- requirements
Module: hash_probe_sequencer

---
 rtl/hash_probe_sequencer_pkg.sv | 16 +
 rtl/hash_probe_sequencer_if.sv | 30 +++
 rtl/hash_probe_sequencer.sv | 86 ++++++++
 tb/tb_hash_probe_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hash_probe_sequencer_pkg.sv
// Shared types and defaults for the tabulation-hash probe path.
// Holds the hash select type and the sequencer FSM state encoding.
package tab_hash_pkg;
    localparam int VPN_W        = 45;
    localparam int HASH_W       = 32;
    localparam int NUM_HASH_MAX = 4;

    typedef logic [1:0] hash_id_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;
endpackage

// File: rtl/hash_probe_sequencer_if.sv
// Request/result handshake plus the hash-unit side channel of the probe sequencer.
// The slave modport is the sequencer view; master is the requester/hash-unit side.
interface hash_probe_sequencer_if
    import tab_hash_pkg::*;
#(
    parameter int NUM_HASH = 4,
    parameter int VPN_W    = tab_hash_pkg::VPN_W,
    parameter int HASH_W   = tab_hash_pkg::HASH_W
);
    logic                       in_valid;
    logic                       in_ready;
    logic [VPN_W-1:0]           in_vpn;
    logic [VPN_W-1:0]           hash_vpn;
    hash_id_t                   hash_id;
    logic [HASH_W-1:0]          hash_result;
    logic                       out_valid;
    logic                       out_ready;
    logic [VPN_W-1:0]           out_vpn;
    logic [NUM_HASH*HASH_W-1:0] out_hash;

    modport slave (
        input  in_valid, in_vpn, hash_result, out_ready,
        output in_ready, hash_vpn, hash_id, out_valid, out_vpn, out_hash
    );

    modport master (
        output in_valid, in_vpn, hash_result, out_ready,
        input  in_ready, hash_vpn, hash_id, out_valid, out_vpn, out_hash
    );
endinterface

// File: rtl/hash_probe_sequencer.sv
// Issues NUM_HASH hash probes for one VPN to an external registered hash unit and
// collects the results into per-id slots; one request in flight at a time.
module hash_probe_sequencer
    import tab_hash_pkg::*;
#(
    parameter int NUM_HASH = 4,
    parameter int VPN_W    = tab_hash_pkg::VPN_W,
    parameter int HASH_W   = tab_hash_pkg::HASH_W
) (
    input logic                    clk,
    input logic                    reset,
    hash_probe_sequencer_if.slave  bus
);
    localparam hash_id_t LAST_ID = hash_id_t'(NUM_HASH - 1);

    state_e                          state_q;
    hash_id_t                        cnt_q;
    logic [VPN_W-1:0]                vpn_q;
    logic [NUM_HASH-1:0][HASH_W-1:0] out_hash_q;
    logic                            cap_vld_q;
    hash_id_t                        cap_id_q;
    logic                            in_ready_q;
    logic                            out_valid_q;

    // The hash unit answers one cycle late, so the id issued last cycle is
    // remembered in cap_id_q and its result lands on the following edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vpn_q       <= '0;
            out_hash_q  <= '0;
            cap_vld_q   <= 1'b0;
            cap_id_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            cap_vld_q <= (state_q == ISSUE);
            cap_id_q  <= cnt_q;
            if (cap_vld_q) begin
                for (int k = 0; k < NUM_HASH; k++) begin
                    if (cap_id_q == hash_id_t'(k)) out_hash_q[k] <= bus.hash_result;
                end
            end

            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        vpn_q      <= bus.in_vpn;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Counter doubles as hash_id, so it returns to 0 on the way out.
                    if (cnt_q == LAST_ID) begin
                        cnt_q   <= '0;
                        state_q <= DRAIN;
                    end else begin
                        cnt_q <= hash_id_t'(cnt_q + 2'd1);
                    end
                end
                DRAIN: begin
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.hash_vpn  = vpn_q;
    assign bus.hash_id   = cnt_q;
    assign bus.out_vpn   = vpn_q;
    assign bus.out_hash  = out_hash_q;
endmodule

// File: tb/tb_hash_probe_sequencer.sv
// Directed bench: a 4-hash and a 2-hash sequencer, each driving a registered hash stub.
module tb_hash_probe_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic bad_id2;

    hash_probe_sequencer_if #(.NUM_HASH(4)) b4 ();
    hash_probe_sequencer_if #(.NUM_HASH(2)) b2 ();

    hash_probe_sequencer #(.NUM_HASH(4)) u4 (.clk(clk), .reset(reset), .bus(b4));
    hash_probe_sequencer #(.NUM_HASH(2)) u2 (.clk(clk), .reset(reset), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        b4.hash_result <= 32'hA000_0000 | {22'd0, b4.hash_id, 8'd0} | {24'd0, b4.hash_vpn[7:0]};
        b2.hash_result <= 32'hA000_0000 | {22'd0, b2.hash_id, 8'd0} | {24'd0, b2.hash_vpn[7:0]};
    end

    initial bad_id2 = 1'b0;
    always @(negedge clk) if (!reset && b2.hash_id > 2'd1) bad_id2 = 1'b1;

    // Counts edges until out_valid is seen; -1 when the budget runs out.
    task automatic wait_out(input int which, output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if ((which == 4) ? b4.out_valid : b2.out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", b4.in_ready, b4.out_valid);
        end
        checks++;
        if (b4.out_hash !== 128'd0 || b4.hash_id !== 2'd0 || b4.hash_vpn !== 45'd0) begin
            failures++; $display("FAIL reset_state: out_hash=%h id=%0d vpn=%h want 0", b4.out_hash, b4.hash_id, b4.hash_vpn);
        end
        checks++;
    endtask

    task automatic test_single();
        logic [31:0] want [4];
        want[0] = 32'hA000_001F; want[1] = 32'hA000_011F;
        want[2] = 32'hA000_021F; want[3] = 32'hA000_031F;
        @(negedge clk); b4.out_ready = 1'b1; b4.in_vpn = 45'h1F; b4.in_valid = 1'b1;
        @(posedge clk); #1; b4.in_valid = 1'b0;
        if (b4.hash_id !== 2'd0 || b4.hash_vpn !== 45'h1F || b4.in_ready !== 1'b0) begin
            failures++; $display("FAIL issue0: id=%0d vpn=%h rdy=%b want 0 1f 0", b4.hash_id, b4.hash_vpn, b4.in_ready);
        end
        checks++;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            if (b4.hash_id !== 2'(k)) begin
                failures++; $display("FAIL issue_id: got %0d want %0d", b4.hash_id, k);
            end
            checks++;
        end
        @(posedge clk); #1;
        if (b4.hash_id !== 2'd0 || b4.out_valid !== 1'b0) begin
            failures++; $display("FAIL drain: id=%0d out_valid=%b want 0 0", b4.hash_id, b4.out_valid);
        end
        checks++;
        @(posedge clk); #1;
        if (b4.out_valid !== 1'b1 || b4.out_vpn !== 45'h1F) begin
            failures++; $display("FAIL latency5: out_valid=%b vpn=%h want 1 1f", b4.out_valid, b4.out_vpn);
        end
        checks++;
        for (int k = 0; k < 4; k++) begin
            if (b4.out_hash[32*k +: 32] !== want[k]) begin
                failures++; $display("FAIL single_slot%0d: got %h want %h", k, b4.out_hash[32*k +: 32], want[k]);
            end
            checks++;
        end
        @(posedge clk); #1;
        if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) begin
            failures++; $display("FAIL single_release: out_valid=%b in_ready=%b want 0 1", b4.out_valid, b4.in_ready);
        end
        checks++;
    endtask

    task automatic test_backpressure();
        int n;
        logic [127:0] held;
        for (int k = 0; k < 4; k++) held[32*k +: 32] = 32'hA000_005A | (32'(k) << 8);
        @(negedge clk); b4.out_ready = 1'b0; b4.in_vpn = 45'h5A; b4.in_valid = 1'b1;
        @(posedge clk); #1; b4.in_valid = 1'b0; b4.in_vpn = 45'hFF;
        wait_out(4, n);
        if (n !== 5) begin
            failures++; $display("FAIL bp_latency: got %0d want 5", n);
        end
        checks++;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); b4.in_vpn = 45'(c + 8'hC0); b4.in_valid = 1'b1;
            @(posedge clk); #1;
            if (b4.out_valid !== 1'b1 || b4.in_ready !== 1'b0 || b4.out_hash !== held || b4.out_vpn !== 45'h5A) begin
                failures++; $display("FAIL bp_hold: ov=%b ir=%b hash=%h vpn=%h want 1 0 %h 5a",
                                     b4.out_valid, b4.in_ready, b4.out_hash, b4.out_vpn, held);
            end
            checks++;
        end
        @(negedge clk); b4.out_ready = 1'b1; b4.in_valid = 1'b0;
        @(posedge clk); #1;
        if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release: ov=%b ir=%b want 0 1", b4.out_valid, b4.in_ready);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk); b4.out_ready = 1'b1; b4.in_vpn = 45'h01; b4.in_valid = 1'b1;
        @(posedge clk); #1; b4.in_vpn = 45'h02;
        wait_out(4, n);
        if (n !== 5 || b4.out_vpn !== 45'h01) begin
            failures++; $display("FAIL b2b_first: lat=%0d vpn=%h want 5 01", n, b4.out_vpn);
        end
        checks++;
        for (int k = 0; k < 4; k++) begin
            if (b4.out_hash[32*k +: 32] !== (32'hA000_0001 | (32'(k) << 8))) begin
                failures++; $display("FAIL b2b_slot_a%0d: got %h", k, b4.out_hash[32*k +: 32]);
            end
            checks++;
        end
        @(posedge clk); #1;
        if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_gap: ir=%b ov=%b want 1 0", b4.in_ready, b4.out_valid);
        end
        checks++;
        @(posedge clk); #1; b4.in_valid = 1'b0;
        if (b4.in_ready !== 1'b0 || b4.hash_vpn !== 45'h02) begin
            failures++; $display("FAIL b2b_accept2: ir=%b vpn=%h want 0 02", b4.in_ready, b4.hash_vpn);
        end
        checks++;
        wait_out(4, n);
        if (n !== 5 || b4.out_vpn !== 45'h02) begin
            failures++; $display("FAIL b2b_second: lat=%0d vpn=%h want 5 02", n, b4.out_vpn);
        end
        checks++;
        for (int k = 0; k < 4; k++) begin
            if (b4.out_hash[32*k +: 32] !== (32'hA000_0002 | (32'(k) << 8))) begin
                failures++; $display("FAIL b2b_slot_b%0d: got %h", k, b4.out_hash[32*k +: 32]);
            end
            checks++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        @(negedge clk); b4.out_ready = 1'b1; b4.in_vpn = 45'h44; b4.in_valid = 1'b1;
        @(posedge clk); #1; b4.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (b4.hash_id !== 2'd2) begin
            failures++; $display("FAIL mid_counter: got %0d want 2", b4.hash_id);
        end
        checks++;
        reset = 1'b1; #1;
        if (b4.in_ready !== 1'b1 || b4.out_valid !== 1'b0 || b4.hash_id !== 2'd0 || b4.out_hash !== 128'd0) begin
            failures++; $display("FAIL mid_abort: ir=%b ov=%b id=%0d hash=%h", b4.in_ready, b4.out_valid, b4.hash_id, b4.out_hash);
        end
        checks++;
        @(negedge clk); reset = 1'b0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (b4.out_valid !== 1'b0) n++;
        end
        if (n !== 0) begin
            failures++; $display("FAIL mid_no_output: out_valid seen %0d times want 0", n);
        end
        checks++;
        @(negedge clk); b4.in_vpn = 45'h33; b4.in_valid = 1'b1;
        @(posedge clk); #1; b4.in_valid = 1'b0;
        wait_out(4, n);
        if (n !== 5 || b4.out_vpn !== 45'h33) begin
            failures++; $display("FAIL post_reset_req: lat=%0d vpn=%h want 5 33", n, b4.out_vpn);
        end
        checks++;
        for (int k = 0; k < 4; k++) begin
            if (b4.out_hash[32*k +: 32] !== (32'hA000_0033 | (32'(k) << 8))) begin
                failures++; $display("FAIL post_reset_slot%0d: got %h", k, b4.out_hash[32*k +: 32]);
            end
            checks++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_num_hash2();
        int n;
        @(negedge clk); b2.out_ready = 1'b1; b2.in_vpn = 45'h07; b2.in_valid = 1'b1;
        @(posedge clk); #1; b2.in_valid = 1'b0;
        wait_out(2, n);
        if (n !== 3) begin
            failures++; $display("FAIL nh2_latency: got %0d want 3", n);
        end
        checks++;
        if (b2.out_hash !== 64'hA000_0107_A000_0007) begin
            failures++; $display("FAIL nh2_slots: got %h want a0000107a0000007", b2.out_hash);
        end
        checks++;
        @(posedge clk); #1;
        if (bad_id2 !== 1'b0 || b2.in_ready !== 1'b1) begin
            failures++; $display("FAIL nh2_ids: bad_id=%b ir=%b want 0 1", bad_id2, b2.in_ready);
        end
        checks++;
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        b4.in_valid = 1'b0; b4.in_vpn = '0; b4.out_ready = 1'b0;
        b2.in_valid = 1'b0; b2.in_vpn = '0; b2.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_num_hash2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
